// File: rtl/foc_loop_sched_if.sv
// foc_loop_sched_if: control and status bundle between the FOC loop
// scheduler and its surroundings (PLL status, current/speed loops, gate driver).
// The master modport is the side that drives requests and status into the
// scheduler. The slave modport is the scheduler itself.
interface foc_loop_sched_if;
  logic       iEnable;
  logic       iPll_locked;
  logic       iModulate_done;
  logic       iFault;
  logic       iClr_fault;
  logic       oCl_en;
  logic       oSl_en;
  logic [2:0] oSD_n;
  logic       oRun;
  logic [1:0] oFault_code;
  logic [2:0] oState;

  modport master (
    output iEnable, iPll_locked, iModulate_done, iFault, iClr_fault,
    input  oCl_en, oSl_en, oSD_n, oRun, oFault_code, oState
  );

  modport slave (
    input  iEnable, iPll_locked, iModulate_done, iFault, iClr_fault,
    output oCl_en, oSl_en, oSD_n, oRun, oFault_code, oState
  );
endinterface

// File: rtl/foc_loop_sched.sv
// foc_loop_sched: control-loop sequencer for the FOC datapath.
// The scheduler waits for LOCK_CYC consecutive PLL-locked cycles and then arms
// the current loop with a one-cycle start pulse. In RUN it fires the speed loop
// once every SPD_DIV modulation periods. It keeps the gate drivers enabled only
// in ARM and RUN, and latches faults until they are cleared.
// Optional feature: define FOC_SCHED_WDOG_EN to add the modulation watchdog
// (fault code 11 when no iModulate_done arrives within WDOG_CYC clocks in RUN).
module foc_loop_sched #(
  parameter int LOCK_CYC = 256,
  parameter int SPD_DIV  = 10,
  parameter int WDOG_CYC = 20000
) (
  input logic             iClk,
  input logic             iRst_n,
  foc_loop_sched_if.slave bus
);

  localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int DEC_W  = (SPD_DIV > 1) ? $clog2(SPD_DIV) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(SPD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCKWAIT = 3'd1,
    ARM      = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t            r_state;
  logic [LOCK_W-1:0] r_lockCnt;
  logic [DEC_W-1:0]  r_decCnt;
  logic              r_clEn;
  logic              r_slEn;
  logic [2:0]        r_sdN;
  logic              r_run;
  logic [1:0]        r_faultCode;
  logic              w_wdogExpired;

`ifdef FOC_SCHED_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

  logic [WDOG_W-1:0] r_wdogCnt;

  // Count clocks since the last modulation pulse; held at zero outside RUN so
  // every RUN entry starts from a fresh count.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_wdogCnt <= '0;
    end else if (r_state != RUN || bus.iModulate_done) begin
      r_wdogCnt <= '0;
    end else if (r_wdogCnt != WDOG_LAST) begin
      r_wdogCnt <= r_wdogCnt + WDOG_W'(1);
    end
  end

  // A modulation pulse in the expiry cycle still counts as alive.
  assign w_wdogExpired = (r_wdogCnt == WDOG_LAST) && !bus.iModulate_done;
`else
  logic w_unusedWdog;

  assign w_wdogExpired = 1'b0;
  assign w_unusedWdog  = (WDOG_CYC > 0);
`endif

  // Sequencer FSM: state, counters and all outputs update together so every
  // output comes straight from a flop.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state     <= IDLE;
      r_lockCnt   <= '0;
      r_decCnt    <= '0;
      r_clEn      <= 1'b0;
      r_slEn      <= 1'b0;
      r_sdN       <= 3'b000;
      r_run       <= 1'b0;
      r_faultCode <= 2'b00;
    end else begin
      r_clEn <= 1'b0;
      r_slEn <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sdN <= 3'b000;
          r_run <= 1'b0;
          if (bus.iEnable) begin
            r_state   <= LOCKWAIT;
            r_lockCnt <= '0;
          end
        end

        LOCKWAIT: begin
          if (bus.iFault) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b01;
          end else if (!bus.iEnable) begin
            r_state <= IDLE;
          end else if (bus.iPll_locked) begin
            if (r_lockCnt == LOCK_LAST) begin
              r_state  <= ARM;
              r_clEn   <= 1'b1;
              r_sdN    <= 3'b111;
              r_decCnt <= '0;
            end else begin
              r_lockCnt <= r_lockCnt + LOCK_W'(1);
            end
          end else begin
            r_lockCnt <= '0;
          end
        end

        ARM: begin
          if (bus.iFault) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b01;
            r_sdN       <= 3'b000;
          end else if (!bus.iPll_locked) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b10;
            r_sdN       <= 3'b000;
          end else begin
            r_state  <= RUN;
            r_run    <= 1'b1;
            r_decCnt <= '0;
          end
        end

        RUN: begin
          if (bus.iFault) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b01;
            r_sdN       <= 3'b000;
            r_run       <= 1'b0;
          end else if (!bus.iPll_locked) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b10;
            r_sdN       <= 3'b000;
            r_run       <= 1'b0;
          end else if (w_wdogExpired) begin
            r_state     <= FAULT;
            r_faultCode <= 2'b11;
            r_sdN       <= 3'b000;
            r_run       <= 1'b0;
          end else if (!bus.iEnable) begin
            r_state <= IDLE;
            r_sdN   <= 3'b000;
            r_run   <= 1'b0;
          end else if (bus.iModulate_done) begin
            if (r_decCnt == DEC_LAST) begin
              r_decCnt <= '0;
              r_slEn   <= 1'b1;
            end else begin
              r_decCnt <= r_decCnt + DEC_W'(1);
            end
          end
        end

        FAULT: begin
          r_sdN <= 3'b000;
          r_run <= 1'b0;
          if (bus.iClr_fault && !bus.iFault) begin
            r_state     <= IDLE;
            r_faultCode <= 2'b00;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_sdN       <= 3'b000;
          r_run       <= 1'b0;
          r_faultCode <= 2'b00;
        end
      endcase
    end
  end

  assign bus.oCl_en      = r_clEn;
  assign bus.oSl_en      = r_slEn;
  assign bus.oSD_n       = r_sdN;
  assign bus.oRun        = r_run;
  assign bus.oFault_code = r_faultCode;
  assign bus.oState      = r_state;

endmodule

// File: tb/tb_foc_loop_sched.sv
// tb_foc_loop_sched: self-checking bench for foc_loop_sched.
// It runs with LOCK_CYC=16, SPD_DIV=10 and WDOG_CYC=100. Expectations follow
// FOC_SCHED_WDOG_EN when that macro is defined for the build.
module tb_foc_loop_sched;

  localparam int LOCK_CYC = 16;
  localparam int SPD_DIV  = 10;
  localparam int WDOG_CYC = 100;
`ifdef FOC_SCHED_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  int   nChecks = 0;
  int   nPass   = 0;

  foc_loop_sched_if bus();

  foc_loop_sched #(
    .LOCK_CYC(LOCK_CYC),
    .SPD_DIV (SPD_DIV),
    .WDOG_CYC(WDOG_CYC)
  ) dut (
    .iClk  (clk),
    .iRst_n(rstN),
    .bus   (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic       en, lock, done, flt, clr;
    logic [2:0] st;
    logic [2:0] sd;
    logic [1:0] code;
    logic       run;
    string      name;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: mode number, locked cycles seen in a row,
  // modulation pulses since RUN entry, quiet clocks since the last pulse.
  int   mState, mLockRun, mDoneCnt, mQuiet, mCode;
  logic mSl;

  task automatic applyStimulus(input logic en, lock, done, flt, clr);
    bus.iEnable        = en;
    bus.iPll_locked    = lock;
    bus.iModulate_done = done;
    bus.iFault         = flt;
    bus.iClr_fault     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic [2:0] sd,
                             input logic [1:0] code, input logic cl, input logic sl, input logic run);
    logic [10:0] got, exp;
    got = {bus.oState, bus.oSD_n, bus.oFault_code, bus.oCl_en, bus.oSl_en, bus.oRun};
    exp = {st, sd, code, cl, sl, run};
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s @%0t: got st=%0d sd=%b code=%b cl=%b sl=%b run=%b, expected st=%0d sd=%b code=%b cl=%b sl=%b run=%b",
                  name, $time, got[10:8], got[7:5], got[4:3], got[2], got[1], got[0],
                  st, sd, code, cl, sl, run);
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rstN = 1'b1;
  endtask

  // From IDLE: one cycle to LOCKWAIT, LOCK_CYC locked cycles to ARM, one to RUN.
  task automatic goRun();
    for (int i = 0; i < LOCK_CYC + 2; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("enter run", 3, 3'b111, 2'b00, 0, 0, 1);
  endtask

  // One clock of the reference model, written directly from the behaviour rules.
  task automatic modelStep(input logic rst, en, lock, done, flt, clr);
    mSl = 1'b0;
    if (!rst) begin
      mState = 0; mCode = 0; mLockRun = 0; mDoneCnt = 0; mQuiet = 0;
    end else if (mState == 0) begin
      if (en) begin mState = 1; mLockRun = 0; end
    end else if (mState == 1) begin
      if (flt) begin mState = 4; mCode = 1; end
      else if (!en) mState = 0;
      else if (lock) begin
        mLockRun++;
        if (mLockRun == LOCK_CYC) mState = 2;
      end else mLockRun = 0;
    end else if (mState == 2) begin
      if (flt) begin mState = 4; mCode = 1; end
      else if (!lock) begin mState = 4; mCode = 2; end
      else begin mState = 3; mDoneCnt = 0; mQuiet = 0; end
    end else if (mState == 3) begin
      if (flt) begin mState = 4; mCode = 1; end
      else if (!lock) begin mState = 4; mCode = 2; end
      else if (WDOG_ON && !done && mQuiet + 1 == WDOG_CYC) begin mState = 4; mCode = 3; end
      else if (!en) mState = 0;
      else if (done) begin
        mDoneCnt++;
        mQuiet = 0;
        if (mDoneCnt % SPD_DIV == 0) mSl = 1'b1;
      end else mQuiet++;
    end else begin
      if (clr && !flt) begin mState = 0; mCode = 0; end
    end
  endtask

  initial begin
    int slCount;
    logic r, e, l, d, f, c;
    logic [2:0] sd;

    rstN = 1'b0;
    bus.iEnable = 0; bus.iPll_locked = 0; bus.iModulate_done = 0;
    bus.iFault = 0; bus.iClr_fault = 0;

    vecs[0] = '{0, 0, 0, 0, 0, 3'd0, 3'b000, 2'b00, 0, "idle hold"};
    vecs[1] = '{1, 0, 0, 0, 0, 3'd1, 3'b000, 2'b00, 0, "enable"};
    vecs[2] = '{1, 1, 0, 1, 0, 3'd4, 3'b000, 2'b01, 0, "ext fault lockwait"};
    vecs[3] = '{1, 1, 0, 1, 1, 3'd4, 3'b000, 2'b01, 0, "clr while fault"};
    vecs[4] = '{1, 1, 0, 0, 1, 3'd0, 3'b000, 2'b00, 0, "clr fault"};
    vecs[5] = '{1, 1, 0, 0, 0, 3'd1, 3'b000, 2'b00, 0, "enable again"};
    vecs[6] = '{0, 1, 0, 0, 0, 3'd0, 3'b000, 2'b00, 0, "disable lockwait"};
    vecs[7] = '{0, 1, 0, 0, 1, 3'd0, 3'b000, 2'b00, 0, "clr in idle"};
    vecs[8] = '{1, 0, 1, 0, 0, 3'd1, 3'b000, 2'b00, 0, "enable no lock"};
    vecs[9] = '{1, 0, 0, 0, 0, 3'd1, 3'b000, 2'b00, 0, "lockwait no lock"};

    // Reset state.
    resetDut();
    checkOutput("reset", 0, 3'b000, 2'b00, 0, 0, 0);

    // Table-driven transitions around IDLE, LOCKWAIT and FAULT.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].lock, vecs[i].done, vecs[i].flt, vecs[i].clr);
      checkOutput(vecs[i].name, vecs[i].st, vecs[i].sd, vecs[i].code, 0, 0, vecs[i].run);
    end

    // Lock qualification: ARM after 16 locked cycles, then RUN.
    resetDut();
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("to lockwait", 1, 3'b000, 2'b00, 0, 0, 0);
    for (int i = 1; i <= LOCK_CYC; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (i < LOCK_CYC) checkOutput("lock counting", 1, 3'b000, 2'b00, 0, 0, 0);
      else              checkOutput("arm", 2, 3'b111, 2'b00, 1, 0, 0);
    end
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("run after arm", 3, 3'b111, 2'b00, 0, 0, 1);

    // Speed-loop decimation: 35 pulses give sl after the 10th, 20th, 30th.
    slCount = 0;
    for (int k = 1; k <= 35; k++) begin
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("decim pulse", 3, 3'b111, 2'b00, 0, (k % 10 == 0), 1);
      if (bus.oSl_en) slCount++;
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("decim gap", 3, 3'b111, 2'b00, 0, 0, 1);
      if (bus.oSl_en) slCount++;
    end
    checkValue("sl pulse count", slCount, 3);

    // External fault on the decimating pulse suppresses oSl_en.
    for (int k = 36; k <= 39; k++) applyStimulus(1, 1, 1, 0, 0);
    checkOutput("pre fault", 3, 3'b111, 2'b00, 0, 0, 1);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("fault beats done", 4, 3'b000, 2'b01, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 1);
    checkOutput("clr ignored", 4, 3'b000, 2'b01, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("fault held", 4, 3'b000, 2'b01, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("fault cleared", 0, 3'b000, 2'b00, 0, 0, 0);

    // Lock drop on the 10th LOCKWAIT cycle restarts qualification.
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lock dropped", 1, 3'b000, 2'b00, 0, 0, 0);
    for (int i = 1; i <= LOCK_CYC; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (i < LOCK_CYC) checkOutput("relock counting", 1, 3'b000, 2'b00, 0, 0, 0);
      else              checkOutput("rearm", 2, 3'b111, 2'b00, 1, 0, 0);
    end
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("rerun", 3, 3'b111, 2'b00, 0, 0, 1);

    // Lock lost in RUN, then reset mid-RUN.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lock lost", 4, 3'b000, 2'b10, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lock fault cleared", 0, 3'b000, 2'b00, 0, 0, 0);
    goRun();
    applyStimulus(1, 1, 1, 0, 0);
    rstN = 1'b0;
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("reset mid run", 0, 3'b000, 2'b00, 0, 0, 0);
    rstN = 1'b1;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("idle after reset", 0, 3'b000, 2'b00, 0, 0, 0);

    // Modulation watchdog: 100 quiet RUN cycles.
    goRun();
    for (int i = 1; i < WDOG_CYC; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("wdog quiet", 3, 3'b111, 2'b00, 0, 0, 1);
    end
    applyStimulus(1, 1, 0, 0, 0);
    if (WDOG_ON) checkOutput("wdog expire", 4, 3'b000, 2'b11, 0, 0, 0);
    else         checkOutput("no wdog", 3, 3'b111, 2'b00, 0, 0, 1);
    for (int i = 0; i < 50; i++) applyStimulus(1, 1, 0, 0, 0);
    if (WDOG_ON) checkOutput("wdog code held", 4, 3'b000, 2'b11, 0, 0, 0);
    else         checkOutput("still running", 3, 3'b111, 2'b00, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("leave wdog test", 0, 3'b000, 2'b00, 0, 0, 0);

    // Randomized run against the reference model.
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    modelStep(0, 0, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      r = ($urandom_range(0, 499) != 0);
      e = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 199) != 0);
      d = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 9) == 0);
      rstN = r;
      applyStimulus(e, l, d, f, c);
      modelStep(r, e, l, d, f, c);
      sd = (mState == 2 || mState == 3) ? 3'b111 : 3'b000;
      checkOutput("random", 3'(mState), sd, 2'(mCode), (mState == 2), mSl, (mState == 3));
    end
    rstN = 1'b1;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
